// File: rtl/axi_datamover_s2mm_ctrl.sv
// axi_datamover_s2mm_ctrl
//
// Write-side controller for the AXI DataMover S2MM channel. It takes one user
// write request (byte address + byte length) and splits it into DataMover
// commands. No command exceeds MAX_BTT bytes or crosses a MAX_BTT-aligned
// boundary. User beats go through a one-entry output register with full
// valid/ready backpressure. Every status beat is checked for OKAY and for the
// expected tag.
//
// Ports
//   clk, rstn                  clock, async active-low reset
//   start, waddr, wdata_len    request strobe, start address, total bytes
//   busy, done, err            request in flight, completion pulse, sticky error
//   wdata_vld, wdata, wready   user data beat handshake
//   s2mm_cmd_*                 DataMover command stream (out)
//   s2mm_t*                    DataMover write data stream (out)
//   s2mm_sts_*                 DataMover status stream (in)
//
// state  | meaning
// IDLE   | waiting for start
// CMD    | presenting one command; waits for cmd_tready
// DATA   | streaming the beats of the current chunk
// DRAIN  | all data sent; waiting for outstanding statuses
// DONE   | one-cycle done pulse

module axi_datamover_s2mm_ctrl #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 24,
  parameter int MAX_BTT    = 4096,
  localparam int BYTES     = DATA_WIDTH / 8,
  localparam int CMD_WIDTH = ADDR_WIDTH + 40
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [LEN_WIDTH-1:0]  wdata_len,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  wready,
  input  logic                  wdata_vld,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [CMD_WIDTH-1:0]  s2mm_cmd_tdata,
  output logic                  s2mm_cmd_tvalid,
  input  logic                  s2mm_cmd_tready,
  output logic [DATA_WIDTH-1:0] s2mm_tdata,
  output logic [BYTES-1:0]      s2mm_tkeep,
  output logic                  s2mm_tlast,
  output logic                  s2mm_tvalid,
  input  logic                  s2mm_tready,
  input  logic [7:0]            s2mm_sts_tdata,
  input  logic                  s2mm_sts_tvalid,
  output logic                  s2mm_sts_tready
);

  localparam int LOG2B   = $clog2(BYTES);
  localparam int MAX_LOG = $clog2(MAX_BTT);
  localparam int CW      = MAX_LOG + 1;                       // holds 0..MAX_BTT
  localparam int XW      = (LEN_WIDTH > CW) ? LEN_WIDTH : CW; // compare width
  localparam int BW      = CW - LOG2B;                        // beats per chunk

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CMD   = 3'd1,
    S_DATA  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  rem_q, rem_d;
  logic [3:0]            tag_q, tag_d;
  logic [3:0]            exp_tag_q, exp_tag_d;
  logic [LEN_WIDTH-1:0]  outst_q, outst_d;
  logic                  err_q, err_d;
  logic [BW-1:0]         beats_q, beats_d;
  logic [BYTES-1:0]      keep_last_q, keep_last_d;
  logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic [BYTES-1:0]      tkeep_q, tkeep_d;
  logic                  tlast_q, tlast_d;
  logic                  tvalid_q, tvalid_d;
  logic                  sts_rdy_q;

  // Chunk sizing: bytes left before the next MAX_BTT boundary, clipped to rem.
  logic [MAX_LOG-1:0] offset;
  logic [CW-1:0]      room;
  logic [XW-1:0]      chunk_x;
  logic [CW-1:0]      chunk;
  logic [BW-1:0]      chunk_beats;
  logic [LOG2B-1:0]   chunk_tail;
  logic [BYTES-1:0]   chunk_keep;
  logic [22:0]        btt;

  assign offset      = addr_q[MAX_LOG-1:0];
  assign room        = CW'(MAX_BTT) - {1'b0, offset};
  assign chunk_x     = (XW'(rem_q) < XW'(room)) ? XW'(rem_q) : XW'(room);
  assign chunk       = CW'(chunk_x);
  assign chunk_tail  = chunk[LOG2B-1:0];
  assign chunk_beats = chunk[CW-1:LOG2B] + BW'(|chunk_tail);
  assign chunk_keep  = (chunk_tail == '0) ? '1 : ((BYTES'(1) << chunk_tail) - BYTES'(1));
  assign btt         = 23'(chunk);

  logic cmd_hs, sts_hs, w_acc, out_take, sts_bad;

  assign cmd_hs   = (state_q == S_CMD) && s2mm_cmd_tready;
  assign sts_hs   = s2mm_sts_tvalid && sts_rdy_q;
  assign w_acc    = wdata_vld && wready;
  assign out_take = tvalid_q && s2mm_tready;
  assign sts_bad  = !s2mm_sts_tdata[7] || (|s2mm_sts_tdata[6:4]) ||
                    (s2mm_sts_tdata[3:0] != exp_tag_q);

  // Output register can take a new beat when empty or being drained this cycle.
  assign wready = (state_q == S_DATA) && (s2mm_tready || !tvalid_q) && (beats_q != '0);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    tag_d       = tag_q;
    exp_tag_d   = exp_tag_q;
    outst_d     = outst_q;
    err_d       = err_q;
    beats_d     = beats_q;
    keep_last_d = keep_last_q;
    tdata_d     = tdata_q;
    tkeep_d     = tkeep_q;
    tlast_d     = tlast_q;
    tvalid_d    = tvalid_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d    = waddr;
          rem_d     = wdata_len;
          exp_tag_d = tag_q;
          err_d     = 1'b0;
          // Rejected requests pass through DRAIN so done lands one cycle later,
          // matching the two-cycle completion of a request with no command.
          if (wdata_len == '0) begin
            state_d = S_DRAIN;
          end else if (waddr[LOG2B-1:0] != '0) begin
            err_d   = 1'b1;
            state_d = S_DRAIN;
          end else begin
            state_d = S_CMD;
          end
        end
      end
      S_CMD: begin
        if (cmd_hs) begin
          addr_d      = addr_q + ADDR_WIDTH'(chunk);
          rem_d       = rem_q - LEN_WIDTH'(chunk);
          tag_d       = tag_q + 4'd1;
          beats_d     = chunk_beats;
          keep_last_d = chunk_keep;
          state_d     = S_DATA;
        end
      end
      S_DATA: begin
        if (out_take && tlast_q) begin
          state_d = (rem_q != '0) ? S_CMD : S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (outst_q == '0) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (w_acc) begin
      tdata_d  = wdata;
      tvalid_d = 1'b1;
      tlast_d  = (beats_q == BW'(1));
      tkeep_d  = (beats_q == BW'(1)) ? keep_last_q : '1;
      beats_d  = beats_q - BW'(1);
    end else if (out_take) begin
      tvalid_d = 1'b0;
      tlast_d  = 1'b0;
    end

    // A status with nothing outstanding is dropped but still flags an error.
    if (sts_hs) begin
      if (outst_q == '0) begin
        err_d = 1'b1;
      end else begin
        if (sts_bad) begin
          err_d = 1'b1;
        end
        exp_tag_d = exp_tag_q + 4'd1;
      end
    end

    case ({cmd_hs, sts_hs && (outst_q != '0)})
      2'b10:   outst_d = outst_q + LEN_WIDTH'(1);
      2'b01:   outst_d = outst_q - LEN_WIDTH'(1);
      default: outst_d = outst_q;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      rem_q       <= '0;
      tag_q       <= '0;
      exp_tag_q   <= '0;
      outst_q     <= '0;
      err_q       <= 1'b0;
      beats_q     <= '0;
      keep_last_q <= '0;
      tdata_q     <= '0;
      tkeep_q     <= '0;
      tlast_q     <= 1'b0;
      tvalid_q    <= 1'b0;
      sts_rdy_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      tag_q       <= tag_d;
      exp_tag_q   <= exp_tag_d;
      outst_q     <= outst_d;
      err_q       <= err_d;
      beats_q     <= beats_d;
      keep_last_q <= keep_last_d;
      tdata_q     <= tdata_d;
      tkeep_q     <= tkeep_d;
      tlast_q     <= tlast_d;
      tvalid_q    <= tvalid_d;
      sts_rdy_q   <= 1'b1;
    end
  end

  assign busy            = (state_q != S_IDLE);
  assign done            = (state_q == S_DONE);
  assign err             = err_q;
  assign s2mm_cmd_tvalid = (state_q == S_CMD);
  // Gated to zero outside CMD so the fixed eof/type bits do not show at reset.
  assign s2mm_cmd_tdata  = (state_q == S_CMD) ?
                           {4'h0, tag_q, addr_q, 1'b0, 1'b1, 6'd0, 1'b1, btt} : '0;
  assign s2mm_tdata      = tdata_q;
  assign s2mm_tkeep      = tkeep_q;
  assign s2mm_tlast      = tlast_q;
  assign s2mm_tvalid     = tvalid_q;
  assign s2mm_sts_tready = sts_rdy_q;

endmodule
